// File: rtl/serial_alu_pkg.sv
// Shared encodings for serial_alu: opcodes, slice select codes, FSM states
// and the opcode-to-slice-control decode.
package serial_alu_pkg;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_SLT = 4'b0111;
   localparam logic [3:0] OP_NOR = 4'b1100;

   localparam logic [1:0] SEL_AND  = 2'b00;
   localparam logic [1:0] SEL_OR   = 2'b01;
   localparam logic [1:0] SEL_ADD  = 2'b10;
   localparam logic [1:0] SEL_LESS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   typedef struct packed {
      logic       valid;
      logic       a_inv;
      logic       b_inv;
      logic       cin;
      logic [1:0] sel;
   } slice_ctrl_t;

   // Unknown opcodes decode to all-zero controls with valid=0; the top forces result to 0.
   function automatic slice_ctrl_t decode_op(input logic [3:0] op);
      slice_ctrl_t c;
      c = '0;
      case (op)
         OP_AND:  c = {1'b1, 1'b0, 1'b0, 1'b0, SEL_AND};
         OP_OR:   c = {1'b1, 1'b0, 1'b0, 1'b0, SEL_OR};
         OP_ADD:  c = {1'b1, 1'b0, 1'b0, 1'b0, SEL_ADD};
         OP_SUB:  c = {1'b1, 1'b0, 1'b1, 1'b1, SEL_ADD};
         OP_SLT:  c = {1'b1, 1'b0, 1'b1, 1'b1, SEL_LESS};
         OP_NOR:  c = {1'b1, 1'b1, 1'b1, 1'b0, SEL_AND};
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/serial_alu_bit.sv
// One-bit ALU slice: optional operand inversion, full adder and a 4:1 result select.
module alu_bit_slice
   import serial_alu_pkg::*;
(
   input  logic       i_a,
   input  logic       i_b,
   input  logic       i_a_inv,
   input  logic       i_b_inv,
   input  logic       i_cin,
   input  logic       i_less,
   input  logic [1:0] i_sel,
   output logic       o_res,
   output logic       o_sum,
   output logic       o_cout
);

   logic w_a;
   logic w_b;

   assign w_a    = i_a ^ i_a_inv;
   assign w_b    = i_b ^ i_b_inv;
   assign o_sum  = w_a ^ w_b ^ i_cin;
   assign o_cout = (w_a & w_b) | (i_cin & (w_a ^ w_b));

   always_comb begin
      o_res = 1'b0;
      case (i_sel)
         SEL_AND:  o_res = w_a & w_b;
         SEL_OR:   o_res = w_a | w_b;
         SEL_ADD:  o_res = o_sum;
         SEL_LESS: o_res = i_less;
         default:  o_res = 1'b0;
      endcase
   end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU, LSB first, one bit per clock through alu_bit_slice.
// Define SERIAL_ALU_FLAGS_EN to expose the cout and overflow ports.
//
// state   | meaning
// IDLE    | ready=1, waiting for start
// RUN     | one operand bit per cycle, WIDTH cycles
// DONE    | one-cycle done pulse, result/flags valid
module serial_alu
   import serial_alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       alu_op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result,
`ifdef SERIAL_ALU_FLAGS_EN
   output logic             zero,
   output logic             cout,
   output logic             overflow
`else
   output logic             zero
`endif
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_result;
   logic [3:0]       r_op;
   logic             r_carry;
   logic             r_zero;

   slice_ctrl_t      w_ctrl;
   logic             w_cin;
   logic             w_res;
   logic             w_sum;
   logic             w_cout;
   logic             w_last;
   logic             w_ovf;
   logic             w_set;
   logic [WIDTH-1:0] w_shift;
   logic [WIDTH-1:0] w_final;

   assign w_ctrl = decode_op(r_op);
   // Bit 0 takes the opcode's carry-in; later bits take the registered carry.
   assign w_cin  = (r_cnt == '0) ? w_ctrl.cin : r_carry;
   assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
   assign w_ovf  = w_cin ^ w_cout;
   assign w_set  = w_sum ^ w_ovf;

   alu_bit_slice u_slice (
      .i_a     (r_a[0]),
      .i_b     (r_b[0]),
      .i_a_inv (w_ctrl.a_inv),
      .i_b_inv (w_ctrl.b_inv),
      .i_cin   (w_cin),
      .i_less  (1'b0),
      .i_sel   (w_ctrl.sel),
      .o_res   (w_res),
      .o_sum   (w_sum),
      .o_cout  (w_cout)
   );

   // New bit enters at the MSB; after WIDTH shifts bit 0 lands at position 0.
   assign w_shift = (r_acc >> 1) | ({{(WIDTH-1){1'b0}}, w_res} << (WIDTH - 1));

   always_comb begin
      w_final = w_shift;
      if (r_op == OP_SLT) begin
         w_final[0] = w_set;
      end
      if (!w_ctrl.valid) begin
         w_final = '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ready       = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            ready = 1'b1;
            if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= '0;
         r_acc    <= '0;
         r_result <= '0;
         r_zero   <= 1'b0;
      end else if (r_state == ST_IDLE && start) begin
         r_a     <= src1;
         r_b     <= src2;
         r_op    <= alu_op;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_acc   <= '0;
      end else if (r_state == ST_RUN) begin
         r_a     <= r_a >> 1;
         r_b     <= r_b >> 1;
         r_carry <= w_cout;
         r_acc   <= w_shift;
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            r_result <= w_final;
            r_zero   <= (w_final == '0);
         end
      end
   end

   assign result = r_result;
   assign zero   = r_zero;

`ifdef SERIAL_ALU_FLAGS_EN
   logic r_cout;
   logic r_ovf;
   logic w_addsub;

   assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (r_state == ST_RUN && w_last) begin
         r_cout <= w_addsub & w_cout;
         r_ovf  <= w_addsub & w_ovf;
      end
   end

   assign cout     = r_cout;
   assign overflow = r_ovf;
`endif

endmodule
